// File: rtl/trng_entropy_sampler.sv
// Ring-oscillator entropy sampler: synchronizer, divided sample tick, repetition-count
// health test, von Neumann debiaser, 8-bit packer and a single-entry valid/ready output.
//
// state       | meaning
// WAIT_FIRST  | waiting for the first sample of a debiaser pair
// WAIT_SECOND | first sample stored in first_q, waiting for the second
module trng_entropy_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 4,
    parameter int REP_LIMIT   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        raw_in,
    input  logic        en,
    input  logic        clr_fail,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        health_fail,
    output logic [15:0] drop_cnt
);

    localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]       REP_MAX  = 8'(REP_LIMIT);

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   prev_q, prev_d;
    logic [7:0]             run_q, run_d;
    logic                   health_fail_q, health_fail_d;
    state_t                 state_q, state_d;
    logic                   first_q, first_d;
    logic [7:0]             sr_q, sr_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic       s;
    logic       tick;
    logic       trip;
    logic       hf_rise;
    logic       abort;
    logic       emit;
    logic       emit_bit;
    logic       byte_done;
    logic [7:0] byte_val;
    logic       accept;

    always_comb begin
        s      = sync_q[SYNC_STAGES-1];
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
        tick   = en && (div_q == DIV_LAST);
        div_d  = '0;
        if (en && (div_q != DIV_LAST)) begin
            div_d = div_q + 1'b1;
        end
    end

    // A run counter of zero marks "no previous sample", so the first tick after
    // reset or clear always starts a fresh run of 1.
    always_comb begin
        run_d  = run_q;
        prev_d = prev_q;
        trip   = 1'b0;
        if (tick) begin
            prev_d = s;
            if ((run_q != 8'd0) && (s == prev_q)) begin
                run_d = (run_q >= REP_MAX) ? REP_MAX : run_q + 8'd1;
            end else begin
                run_d = 8'd1;
            end
            trip = (run_d == REP_MAX);
        end
        if (clr_fail) begin
            run_d         = 8'd0;
            health_fail_d = 1'b0;
        end else begin
            health_fail_d = health_fail_q | trip;
        end
        hf_rise = health_fail_d & ~health_fail_q;
        abort   = ~en | hf_rise;
    end

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        emit     = 1'b0;
        emit_bit = first_q;
        if (abort) begin
            state_d = WAIT_FIRST;
        end else if (tick && !health_fail_q) begin
            case (state_q)
                WAIT_FIRST: begin
                    first_d = s;
                    state_d = WAIT_SECOND;
                end
                WAIT_SECOND: begin
                    state_d = WAIT_FIRST;
                    emit    = first_q ^ s;
                end
                default: state_d = WAIT_FIRST;
            endcase
        end
    end

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        byte_done = 1'b0;
        byte_val  = sr_q;
        if (abort) begin
            sr_d      = 8'd0;
            bit_cnt_d = 3'd0;
        end else if (emit) begin
            byte_val[bit_cnt_q] = emit_bit;
            if (bit_cnt_q == 3'd7) begin
                byte_done = 1'b1;
                sr_d      = 8'd0;
                bit_cnt_d = 3'd0;
            end else begin
                sr_d      = byte_val;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    // A completed byte may replace the held one only when that one leaves this cycle.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        drop_cnt_d  = drop_cnt_q;
        accept      = out_valid_q & out_ready;
        if (byte_done) begin
            if (!out_valid_q || accept) begin
                out_data_d  = byte_val;
                out_valid_d = 1'b1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            div_q         <= '0;
            prev_q        <= 1'b0;
            run_q         <= 8'd0;
            health_fail_q <= 1'b0;
            state_q       <= WAIT_FIRST;
            first_q       <= 1'b0;
            sr_q          <= 8'd0;
            bit_cnt_q     <= 3'd0;
            out_data_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            drop_cnt_q    <= 16'd0;
        end else begin
            sync_q        <= sync_d;
            div_q         <= div_d;
            prev_q        <= prev_d;
            run_q         <= run_d;
            health_fail_q <= health_fail_d;
            state_q       <= state_d;
            first_q       <= first_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign health_fail = health_fail_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_trng_entropy_sampler.sv
// Bench for trng_entropy_sampler: a sample-level reference model checked every cycle,
// a table of pair patterns with expected bytes, and directed multi-cycle corner cases.
module tb_trng_entropy_sampler;

    localparam int SYNC_STAGES = 2;
    localparam int SAMPLE_DIV  = 4;
    localparam int REP_LIMIT   = 32;

    logic        clk;
    logic        rst_n;
    logic        raw_in;
    logic        en;
    logic        clr_fail;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        health_fail;
    logic [15:0] drop_cnt;

    trng_entropy_sampler #(
        .SYNC_STAGES(SYNC_STAGES),
        .SAMPLE_DIV (SAMPLE_DIV),
        .REP_LIMIT  (REP_LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .en         (en),
        .clr_fail   (clr_fail),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .health_fail(health_fail),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit         m_pipe[$];
    int         m_en_run;
    int         m_run;
    bit         m_prev;
    bit         m_fail;
    int         m_pend;
    bit         m_bits[$];
    bit         m_valid;
    logic [7:0] m_data;
    int         m_drop;

    typedef struct {
        logic [19:0] pairs;
        int          n_pairs;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
        m_en_run = 0;
        m_run    = 0;
        m_prev   = 1'b0;
        m_fail   = 1'b0;
        m_pend   = -1;
        m_bits.delete();
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_drop   = 0;
    endtask

    task automatic model_step();
        bit         s;
        bit         tick;
        bit         old_fail;
        bit         rise;
        bit         load;
        bit         acc;
        logic [7:0] b;
        s = m_pipe.pop_front();
        m_pipe.push_back(raw_in);
        tick     = en && ((m_en_run % SAMPLE_DIV) == SAMPLE_DIV - 1);
        m_en_run = en ? m_en_run + 1 : 0;
        old_fail = m_fail;
        if (clr_fail) begin
            m_run  = 0;
            m_fail = 1'b0;
        end else if (tick) begin
            if (m_run > 0 && s == m_prev) m_run = (m_run >= REP_LIMIT) ? REP_LIMIT : m_run + 1;
            else m_run = 1;
            m_prev = s;
            if (m_run == REP_LIMIT) m_fail = 1'b1;
        end
        rise = m_fail && !old_fail;
        load = 1'b0;
        b    = 8'h00;
        if (!en || rise) begin
            m_pend = -1;
            m_bits.delete();
        end else if (tick && !old_fail) begin
            if (m_pend < 0) begin
                m_pend = int'(s);
            end else begin
                if (m_pend != int'(s)) m_bits.push_back(m_pend[0]);
                m_pend = -1;
            end
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) b[i] = m_bits[i];
                m_bits.delete();
                load = 1'b1;
            end
        end
        acc = m_valid && out_ready;
        if (load) begin
            if (!m_valid || acc) begin
                m_data  = b;
                m_valid = 1'b1;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end else if (acc) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", 16'(out_valid), 16'(m_valid));
        chk("out_data", 16'(out_data), 16'(m_data));
        chk("health_fail", 16'(health_fail), 16'(m_fail));
        chk("drop_cnt", drop_cnt, 16'(m_drop));
        @(negedge clk);
    endtask

    task automatic feed(input bit b);
        raw_in = b;
        repeat (SAMPLE_DIV) cyc();
    endtask

    task automatic feed_pairs(input logic [19:0] pairs, input int n);
        logic [19:0] p;
        p = pairs;
        for (int i = 0; i < n; i++) begin
            feed(p[2*i+1]);
            feed(p[2*i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        en       = 1'b0;
        raw_in   = 1'b0;
        clr_fail = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{pairs: 20'h0AAAA, n_pairs: 8,  exp_byte: 8'hFF};
        vecs[1] = '{pairs: 20'h05555, n_pairs: 8,  exp_byte: 8'h00};
        vecs[2] = '{pairs: 20'h66636, n_pairs: 10, exp_byte: 8'h55};
        vecs[3] = '{pairs: 20'h055AA, n_pairs: 8,  exp_byte: 8'h0F};

        rst_n = 1'b0; en = 1'b0; raw_in = 1'b0; clr_fail = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        chk("reset_valid", 16'(out_valid), 16'h0);
        chk("reset_data", 16'(out_data), 16'h0);
        chk("reset_drop", drop_cnt, 16'h0);
        chk("reset_fail", 16'(health_fail), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Constant-zero source trips the repetition test on the 32nd tick
        en = 1'b1; raw_in = 1'b0;
        repeat (127) cyc();
        chk("t1_no_trip_yet", 16'(health_fail), 16'h0);
        cyc();
        chk("t1_trip", 16'(health_fail), 16'h1);
        clr_fail = 1'b1;
        cyc();
        clr_fail = 1'b0;
        chk("t1_cleared", 16'(health_fail), 16'h0);
        repeat (126) cyc();
        chk("t1_no_retrip_yet", 16'(health_fail), 16'h0);
        cyc();
        chk("t1_retrip", 16'(health_fail), 16'h1);
        chk("t1_never_valid", 16'(out_valid), 16'h0);

        do_reset();

        for (int v = 0; v < 4; v++) begin
            out_ready = 1'b0;
            en = 1'b1;
            feed_pairs(vecs[v].pairs, vecs[v].n_pairs);
            chk("tbl_valid", 16'(out_valid), 16'h1);
            chk("tbl_byte", 16'(out_data), 16'(vecs[v].exp_byte));
            en = 1'b0; out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
            chk("tbl_accepted", 16'(out_valid), 16'h0);
        end

        // Backpressure: second byte dropped, first held
        en = 1'b1; out_ready = 1'b0;
        feed_pairs(20'h0AAAA, 8);
        feed_pairs(20'h05555, 8);
        chk("t3_held_byte", 16'(out_data), 16'hFF);
        chk("t3_drop", drop_cnt, 16'd1);
        en = 1'b0; out_ready = 1'b1;
        cyc();
        chk("t3_accept", 16'(out_valid), 16'h0);
        out_ready = 1'b0;

        // Accept and load in the same cycle
        en = 1'b1;
        feed_pairs(20'h0AAAA, 8);
        feed_pairs(20'h055AA, 7);
        feed(1'b0);
        raw_in = 1'b1;
        repeat (SAMPLE_DIV - 1) cyc();
        out_ready = 1'b1;
        cyc();
        chk("t4_valid_kept", 16'(out_valid), 16'h1);
        chk("t4_new_byte", 16'(out_data), 16'h0F);
        chk("t4_drop_same", drop_cnt, 16'd1);
        en = 1'b0;
        cyc();
        chk("t4_drained", 16'(out_valid), 16'h0);
        out_ready = 1'b0;

        // Abort mid-byte with a half pair pending
        en = 1'b1;
        feed_pairs(20'h00155, 5);
        feed(1'b1);
        en = 1'b0;
        cyc();
        en = 1'b1;
        feed_pairs(20'h0AAAA, 8);
        chk("t5_clean_byte", 16'(out_data), 16'hFF);
        en = 1'b0; out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Randomized stimulus against the model
        for (int i = 0; i < 2500; i++) begin
            en        = ($urandom_range(0, 49) != 0);
            raw_in    = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_fail  = ($urandom_range(0, 199) == 0);
            cyc();
        end
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 99) != 0);
            raw_in    = ($urandom_range(0, 99) < 96);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_fail  = ($urandom_range(0, 299) == 0);
            cyc();
        end

        // Asynchronous reset mid-byte while a byte is held
        en = 1'b0; out_ready = 1'b0; clr_fail = 1'b1;
        cyc();
        clr_fail = 1'b0;
        en = 1'b1;
        feed_pairs(20'h0AAAA, 8);
        feed_pairs(20'h0AAAA, 3);
        chk("t6_pre_valid", 16'(out_valid), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 16'(out_valid), 16'h0);
        chk("t6_async_data", 16'(out_data), 16'h0);
        chk("t6_async_drop", drop_cnt, 16'h0);
        chk("t6_async_fail", 16'(health_fail), 16'h0);
        model_reset();
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        feed_pairs(20'h055AA, 8);
        chk("t6_no_partial", 16'(out_data), 16'h0F);
        chk("t6_valid_again", 16'(out_valid), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
